// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the PC over a 16-bit instruction memory,
// merges one- and two-word instructions into a 32-bit bus for decode,
// and handles downstream stall and taken-branch redirects.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH1 | memData is an opcode word; short ones issue, long ones park
// FETCH2 | memData is the immediate word of the parked long opcode
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           memData,
  output logic [ADDR_WIDTH-1:0] memAddress,
  input  logic                  stall,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  output logic [31:0]           instruction,
  output logic                  instrValid,
  output logic [ADDR_WIDTH-1:0] instrPC
);

  typedef enum logic {
    FETCH1 = 1'b0,
    FETCH2 = 1'b1
  } fetchState_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  fetchState_t           state;
  fetchState_t           nextState;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] nextPc;
  logic [ADDR_WIDTH-1:0] pcPlusOne;
  logic [15:0]           holdWord;
  logic [15:0]           nextHoldWord;
  logic [ADDR_WIDTH-1:0] holdPC;
  logic [ADDR_WIDTH-1:0] nextHoldPC;
  logic [31:0]           nextInstruction;
  logic                  nextInstrValid;
  logic [ADDR_WIDTH-1:0] nextInstrPC;
  logic                  isLong;

  // Memory is read combinationally at the current PC; wraps naturally.
  assign memAddress = pc;
  assign pcPlusOne  = pc + PC_ONE;
  assign isLong     = memData[15];

  // Next-state and next-output selection: branch beats stall beats fetch.
  always_comb begin
    nextState       = state;
    nextPc          = pc;
    nextHoldWord    = holdWord;
    nextHoldPC      = holdPC;
    nextInstruction = instruction;
    nextInstrValid  = instrValid;
    nextInstrPC     = instrPC;

    if (branchTaken) begin
      // Redirect wins even while stalled; a parked opcode is dropped.
      nextPc          = branchTarget;
      nextState       = FETCH1;
      nextHoldWord    = 16'h0000;
      nextInstruction = 32'h0000_0000;
      nextInstrValid  = 1'b0;
      nextInstrPC     = '0;
    end else if (!stall) begin
      unique case (state)
        FETCH1: begin
          nextPc = pcPlusOne;
          if (isLong) begin
            // Park the opcode; output a bubble but keep the old payload.
            nextHoldWord   = memData;
            nextHoldPC     = pc;
            nextState      = FETCH2;
            nextInstrValid = 1'b0;
          end else begin
            nextInstruction = {16'h0000, memData};
            nextInstrValid  = 1'b1;
            nextInstrPC     = pc;
          end
        end
        FETCH2: begin
          nextPc          = pcPlusOne;
          nextInstruction = {memData, holdWord};
          nextInstrValid  = 1'b1;
          nextInstrPC     = holdPC;
          nextState       = FETCH1;
        end
        default: begin
          nextState = FETCH1;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH1;
    end else begin
      state <= nextState;
    end
  end

  // PC, parked opcode and registered decode outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      holdWord    <= 16'h0000;
      holdPC      <= '0;
      instruction <= 32'h0000_0000;
      instrValid  <= 1'b0;
      instrPC     <= '0;
    end else begin
      pc          <= nextPc;
      holdWord    <= nextHoldWord;
      holdPC      <= nextHoldPC;
      instruction <= nextInstruction;
      instrValid  <= nextInstrValid;
      instrPC     <= nextInstrPC;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural instruction memory plus
// scenario tasks comparing {instrValid, instrPC, instruction, memAddress}.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] memData;
  logic [15:0] memAddress;
  logic        stall;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic [31:0] instruction;
  logic        instrValid;
  logic [15:0] instrPC;

  logic [15:0] mem [0:65535];
  int          testsRun;
  int          testsFailed;
  logic [64:0] obs;
  logic [64:0] exp;

  fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .memData      (memData),
    .memAddress   (memAddress),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .instruction  (instruction),
    .instrValid   (instrValid),
    .instrPC      (instrPC)
  );

  assign memData = mem[memAddress];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b0, 16'h0000, 32'h0000_0000, 16'h0000};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL reset_state: got %h want %h", obs, exp); end
  endtask

  task automatic test_straight_line();
    rst = 1'b1;
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0000, 32'h0000_6666, 16'h0001};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL straight_pc0: got %h want %h", obs, exp); end
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0001, 32'h0000_6083, 16'h0002};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL straight_pc1: got %h want %h", obs, exp); end
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0002, 32'h0000_1234, 16'h0003};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL straight_pc2: got %h want %h", obs, exp); end
  endtask

  task automatic test_two_word();
    branchTaken = 1'b1; branchTarget = 16'h0004;
    tick();
    branchTaken = 1'b0;
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b0, 16'h0000, 32'h0000_0000, 16'h0004};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL two_word_redirect: got %h want %h", obs, exp); end
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b0, 16'h0000, 32'h0000_0000, 16'h0005};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL two_word_bubble: got %h want %h", obs, exp); end
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0004, 32'hBEEF_8005, 16'h0006};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL two_word_issue: got %h want %h", obs, exp); end
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0006, 32'h0000_0001, 16'h0007};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL two_word_follow: got %h want %h", obs, exp); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {instrValid, instrPC, instruction, memAddress};
      exp = {1'b1, 16'h0006, 32'h0000_0001, 16'h0007};
      testsRun++;
      if (obs !== exp) begin testsFailed++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp); end
    end
    stall = 1'b0;
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0007, 32'h0000_0202, 16'h0008};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL stall_release: got %h want %h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b0, 16'h0007, 32'h0000_0202, 16'h0009};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL bubble_keeps_payload: got %h want %h", obs, exp); end
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0008, 32'h4567_8123, 16'h000A};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL back_to_back_long: got %h want %h", obs, exp); end
  endtask

  task automatic test_stall_fetch2();
    branchTaken = 1'b1; branchTarget = 16'h0004;
    tick();
    branchTaken = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      obs = {instrValid, instrPC, instruction, memAddress};
      exp = {1'b0, 16'h0000, 32'h0000_0000, 16'h0005};
      testsRun++;
      if (obs !== exp) begin testsFailed++; $display("FAIL stall_fetch2_hold_%0d: got %h want %h", i, obs, exp); end
    end
    stall = 1'b0;
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0004, 32'hBEEF_8005, 16'h0006};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL stall_fetch2_issue: got %h want %h", obs, exp); end
  endtask

  task automatic test_branch_fetch2();
    branchTaken = 1'b1; branchTarget = 16'h0004;
    tick();
    branchTaken = 1'b0;
    tick();
    branchTaken = 1'b1; branchTarget = 16'h0040;
    tick();
    branchTaken = 1'b0;
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b0, 16'h0000, 32'h0000_0000, 16'h0040};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL branch_fetch2_redirect: got %h want %h", obs, exp); end
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0040, 32'h0000_0011, 16'h0041};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL branch_target_issue: got %h want %h", obs, exp); end
    stall = 1'b1; branchTaken = 1'b1; branchTarget = 16'h0050;
    tick();
    branchTaken = 1'b0;
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b0, 16'h0000, 32'h0000_0000, 16'h0050};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL branch_under_stall: got %h want %h", obs, exp); end
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL branch_stall_hold: got %h want %h", obs, exp); end
    stall = 1'b0;
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0050, 32'h0000_0022, 16'h0051};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL branch_stall_issue: got %h want %h", obs, exp); end
  endtask

  task automatic test_wrap();
    mem[16'h0000] = 16'h00AA;
    mem[16'hFFFF] = 16'h9000;
    branchTaken = 1'b1; branchTarget = 16'hFFFF;
    tick();
    branchTaken = 1'b0;
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b0, 16'h0000, 32'h0000_0000, 16'h0000};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL wrap_bubble: got %h want %h", obs, exp); end
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'hFFFF, 32'h00AA_9000, 16'h0001};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL wrap_issue: got %h want %h", obs, exp); end
  endtask

  task automatic test_async_reset();
    branchTaken = 1'b1; branchTarget = 16'h0040;
    tick();
    branchTaken = 1'b0;
    tick();
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b0, 16'h0040, 32'h0000_0011, 16'h0042};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL pre_reset_fetch2: got %h want %h", obs, exp); end
    #2;
    rst = 1'b0;
    #1;
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b0, 16'h0000, 32'h0000_0000, 16'h0000};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL async_reset: got %h want %h", obs, exp); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    obs = {instrValid, instrPC, instruction, memAddress};
    exp = {1'b1, 16'h0000, 32'h0000_00AA, 16'h0001};
    testsRun++;
    if (obs !== exp) begin testsFailed++; $display("FAIL post_reset_fetch: got %h want %h", obs, exp); end
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    rst          = 1'b0;
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h6666;
    mem[16'h0001] = 16'h6083;
    mem[16'h0002] = 16'h1234;
    mem[16'h0004] = 16'h8005;
    mem[16'h0005] = 16'hBEEF;
    mem[16'h0006] = 16'h0001;
    mem[16'h0007] = 16'h0202;
    mem[16'h0008] = 16'h8123;
    mem[16'h0009] = 16'h4567;
    mem[16'h0040] = 16'h0011;
    mem[16'h0041] = 16'h8777;
    mem[16'h0050] = 16'h0022;

    test_reset();
    test_straight_line();
    test_two_word();
    test_stall();
    test_back_to_back();
    test_stall_fetch2();
    test_branch_fetch2();
    test_wrap();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the instruction stream consumed by the decode stage. It walks a program counter over a 16-bit-wide, combinationally-read instruction memory. It assembles one-word and two-word (immediate-carrying) instructions into the 32-bit instruction bus and presents them registered to decode together with a valid flag and the instruction's address. It honours a stall from downstream hazard logic and redirects on taken branches.

## Interface
- ADDR_WIDTH, 16, width of program counter and instruction memory address
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- memData  input  16  instruction memory read data for memAddress, valid same cycle
- memAddress  output  ADDR_WIDTH  instruction memory read address, equals current PC
- stall  input  1  downstream cannot accept; freeze all fetch state
- branchTaken  input  1  redirect request this cycle
- branchTarget  input  ADDR_WIDTH  redirect address
- instruction  output  32  [15:0] opcode word, [31:16] immediate word (0 for one-word instructions)
- instrValid  output  1  instruction holds a real instruction this cycle
- instrPC  output  ADDR_WIDTH  address of the opcode word of instruction

## Operation
- Registers: pc, state (FETCH1/FETCH2), holdWord[15:0], holdPC, plus registered outputs instruction, instrValid, instrPC.
- memAddress = pc, combinational.
- Long-instruction marker: memData[15]==1 in the opcode word means a second (immediate) word follows.
- Per-edge priority: reset > branchTaken > stall > normal fetch.
- branchTaken: pc<=branchTarget, state<=FETCH1, instruction<=0, instrValid<=0, instrPC<=0, holdWord discarded. Applies in either state, stalled or not.
- stall (no branch): pc, state, holdWord, holdPC, and all outputs keep their values.
- FETCH1, memData[15]==0: instruction<={16'h0000, memData}, instrValid<=1, instrPC<=pc, pc<=pc+1, stay FETCH1.
- FETCH1, memData[15]==1: holdWord<=memData, holdPC<=pc, pc<=pc+1, state<=FETCH2, instrValid<=0 (bubble; instruction and instrPC unchanged).
- FETCH2: instruction<={memData, holdWord}, instrValid<=1, instrPC<=holdPC, pc<=pc+1, state<=FETCH1.
- PC arithmetic is modulo 2^ADDR_WIDTH. pc+1 from all-ones wraps to 0. A two-word instruction whose opcode sits at the last address takes its immediate from address 0.

## Timing
- Reset (asynchronous assert, any time, including mid two-word fetch): pc=RESET_PC, state=FETCH1, holdWord=0, holdPC=0, instruction=0, instrValid=0, instrPC=0. memAddress=RESET_PC immediately.
- One-word instruction: appears on outputs at the edge after its address is presented, so latency is 1 cycle. Throughput is 1 per cycle.
- Two-word instruction: appears 2 cycles after the opcode address is presented, with one instrValid=0 bubble in between. Throughput is 1 per 2 cycles.
- First valid output after reset release comes at the first rising edge with rst high and stall low.
- Branch: the edge with branchTaken high produces instrValid=0. On the next edge, the instruction at branchTarget appears if it is one word.
- Stall raised during FETCH2: holdWord is retained. The immediate is read when stall drops.
- The output seen by decode is stable during stall. Decode captures on the cycle stall is low.

## Test plan
- Reset/straight-line: memory[0..2]=16'h6666,16'h6083,16'h1234; release rst -> edges yield instruction 32'h00006666/PC0, 32'h00006083/PC1, 32'h00001234/PC2, instrValid=1 each cycle; memAddress 0,1,2,3.
- Two-word: memory[4]=16'h8005, memory[5]=16'hBEEF, memory[6]=16'h0001 from pc=4 -> cycle1 instrValid=0, cycle2 instruction=32'hBEEF8005 instrPC=4, cycle3 32'h00000001 instrPC=6.
- Stall: hold stall=1 for 3 cycles mid-stream -> memAddress, instruction, instrValid, instrPC unchanged; the same stall asserted in FETCH2 of the 8005/BEEF pair still yields 32'hBEEF8005 after release.
- Branch in FETCH2: branchTaken=1, branchTarget=16'h0040 during the BEEF fetch -> instrValid=0 that edge, memAddress=0x0040 next, the held 8005 never issued; branch with stall=1 still redirects.
- Wrap: pc=16'hFFFF holding 16'h9000, memory[0]=16'h00AA -> instruction=32'h00AA9000, instrPC=16'hFFFF, next pc=1.
- Async reset mid-FETCH2: drop rst between edges -> all outputs 0 and memAddress=RESET_PC immediately, without waiting for clk.
